// File: rtl/fft_pkg.sv
// fft_pkg: shared FFT constants and controller state encoding
package fft_pkg;
  localparam int FFT_N = 16;
  localparam int FFT_ADDR_W = 4;
  localparam int FFT_STAGES = 4;
  typedef enum logic [2:0] {IDLE = 3'd0, LOAD = 3'd1, CALC = 3'd2, WAIT = 3'd3, DONE = 3'd4} fft_state_e;
endpackage

// File: rtl/fft_wait_cnt.sv
// fft_wait_cnt: loadable down-counter with zero flag, stops at zero
module fft_wait_cnt #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic         en_i,
  input  logic [W-1:0] val_i,
  output logic         zero_o
);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = load_i ? val_i : (en_i && cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign zero_o = cnt_q == '0;
endmodule

// File: rtl/fft_stage_ctrl.sv
// fft_stage_ctrl: sequences load/calc/wait passes of fft_reg_stage over all radix-2 stages.
// Define FFT_CTRL_ABORT_EN to add the abort_i input that returns the FSM to IDLE.
module fft_stage_ctrl
  import fft_pkg::*;
#(
  parameter int N           = FFT_N,
  parameter int ADDR_W      = FFT_ADDR_W,
  parameter int STAGES      = FFT_STAGES,
  parameter int STAGE_W     = 2,
  parameter int CALC_CYCLES = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
`ifdef FFT_CTRL_ABORT_EN
  input  logic               abort_i,
`endif
  output logic               fill_regs_o,
  output logic               we_regs_o,
  output logic [ADDR_W-1:0]  addr_counter_o,
  output logic               sel_in_o,
  output logic               start_calc_o,
  output logic [STAGE_W-1:0] stage_o,
  output logic               busy_o,
  output logic               done_o
);
  localparam int CW = $clog2(CALC_CYCLES + 1);
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(N - 1);
  localparam logic [STAGE_W-1:0] STAGE_LAST = STAGE_W'(STAGES - 1);
  fft_state_e state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [STAGE_W-1:0] stage_q, stage_d;
  logic sel_q, sel_d, fill_q, fill_d, we_q, we_d, calc_q, calc_d, busy_q, busy_d, done_q, done_d;
  logic wait_zero;
  fft_wait_cnt #(.W(CW)) u_wait (
    .clk    (clk),
    .rst    (rst),
    .load_i (state_q == CALC),
    .en_i   (state_q == WAIT),
    .val_i  (CW'(CALC_CYCLES - 1)),
    .zero_o (wait_zero)
  );
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    stage_d = stage_q;
    sel_d   = sel_q;
    fill_d  = 1'b0;
    we_d    = we_q;
    calc_d  = 1'b0;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: if (start_i) begin
        state_d = LOAD;
        addr_d  = '0;
        stage_d = '0;
        sel_d   = 1'b0;
        fill_d  = 1'b1;
        we_d    = 1'b1;
        busy_d  = 1'b1;
      end
      LOAD: begin
        state_d = addr_q == ADDR_LAST ? CALC : LOAD;
        addr_d  = addr_q == ADDR_LAST ? '0 : addr_q + 1'b1;
        we_d    = addr_q != ADDR_LAST;
        calc_d  = addr_q == ADDR_LAST;
      end
      CALC: state_d = WAIT;
      WAIT: if (wait_zero) begin
        if (stage_q != STAGE_LAST) begin
          state_d = LOAD;
          stage_d = stage_q + 1'b1;
          sel_d   = 1'b1;
          fill_d  = 1'b1;
          we_d    = 1'b1;
          addr_d  = '0;
        end else begin
          state_d = DONE;
          done_d  = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
        sel_d   = 1'b0;
        stage_d = '0;
        busy_d  = 1'b0;
      end
      default: state_d = IDLE;
    endcase
`ifdef FFT_CTRL_ABORT_EN
    if (abort_i && state_q != IDLE) begin
      state_d = IDLE;
      addr_d  = '0;
      stage_d = '0;
      sel_d   = 1'b0;
      fill_d  = 1'b0;
      we_d    = 1'b0;
      calc_d  = 1'b0;
      busy_d  = 1'b0;
      done_d  = 1'b0;
    end
`endif
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      stage_q <= '0;
      sel_q   <= 1'b0;
      fill_q  <= 1'b0;
      we_q    <= 1'b0;
      calc_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      stage_q <= stage_d;
      sel_q   <= sel_d;
      fill_q  <= fill_d;
      we_q    <= we_d;
      calc_q  <= calc_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  assign fill_regs_o    = fill_q;
  assign we_regs_o      = we_q;
  assign addr_counter_o = addr_q;
  assign sel_in_o       = sel_q;
  assign start_calc_o   = calc_q;
  assign stage_o        = stage_q;
  assign busy_o         = busy_q;
  assign done_o         = done_q;
endmodule

// File: tb/tb_fft_stage_ctrl.sv
// tb_fft_stage_ctrl: random and directed runs of two controllers (CALC_CYCLES 8 and 1) against a run-position model
module tb_fft_stage_ctrl;
  localparam int N = 16;
  localparam int ST = 4;
  localparam int LA = ST * (N + 1 + 8);
  localparam int LB = ST * (N + 1 + 1);
  logic clk = 0, rst = 0, start_a = 0, start_b = 0, abort_a = 0, abort_b = 0;
  logic fill_a, we_a, sel_a, calc_a, busy_a, done_a, fill_b, we_b, sel_b, calc_b, busy_b, done_b;
  logic [3:0] addr_a, addr_b;
  logic [1:0] stage_a, stage_b;
  logic [12:0] pack_a, pack_b;
  int ka = -1, kb = -1;
  int vectors = 0, miscompares = 0;
  int calc_cnt[2] = '{0, 0}, done_cnt[2] = '{0, 0};
  logic [1:0] sq_a[$], sq_b[$];
  always #5 clk = ~clk;
  fft_stage_ctrl #(.CALC_CYCLES(8)) dut_a (
    .clk(clk), .rst(rst), .start_i(start_a),
`ifdef FFT_CTRL_ABORT_EN
    .abort_i(abort_a),
`endif
    .fill_regs_o(fill_a), .we_regs_o(we_a), .addr_counter_o(addr_a), .sel_in_o(sel_a),
    .start_calc_o(calc_a), .stage_o(stage_a), .busy_o(busy_a), .done_o(done_a));
  fft_stage_ctrl #(.CALC_CYCLES(1)) dut_b (
    .clk(clk), .rst(rst), .start_i(start_b),
`ifdef FFT_CTRL_ABORT_EN
    .abort_i(abort_b),
`endif
    .fill_regs_o(fill_b), .we_regs_o(we_b), .addr_counter_o(addr_b), .sel_in_o(sel_b),
    .start_calc_o(calc_b), .stage_o(stage_b), .busy_o(busy_b), .done_o(done_b));
  assign pack_a = {fill_a, we_a, addr_a, sel_a, calc_a, stage_a, busy_a, done_a};
  assign pack_b = {fill_b, we_b, addr_b, sel_b, calc_b, stage_b, busy_b, done_b};
  // k is the number of edges since the accepting start edge; -1 means idle
  function automatic logic [12:0] exp_out(int k, int c);
    int p, s, r;
    logic [3:0] a;
    logic [1:0] sg;
    p = N + 1 + c;
    if (k < 0) return '0;
    if (k == ST * p) return {2'b00, 4'd0, 1'b1, 1'b0, 2'd3, 2'b11};
    s = k / p;
    r = k % p;
    a = (r < N) ? 4'(r) : 4'd0;
    sg = 2'(s);
    return {r == 0, r < N, a, s > 0, r == N, sg, 1'b1, 1'b0};
  endfunction
  function automatic int step(int k, logic st, logic ab, int l);
    if (k >= 0 && ab) return -1;
    if (k >= 0) return k == l ? -1 : k + 1;
    return st ? 0 : -1;
  endfunction
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  always @(posedge clk or posedge rst)
    if (rst) begin
      ka <= -1;
      kb <= -1;
    end else begin
`ifdef FFT_CTRL_ABORT_EN
      ka <= step(ka, start_a, abort_a, LA);
      kb <= step(kb, start_b, abort_b, LB);
`else
      ka <= step(ka, start_a, 1'b0, LA);
      kb <= step(kb, start_b, 1'b0, LB);
`endif
    end
  always @(posedge clk) begin
    #1;
    check("out_a", 32'(pack_a), 32'(exp_out(ka, 8)));
    check("out_b", 32'(pack_b), 32'(exp_out(kb, 1)));
    if (calc_a) begin calc_cnt[0]++; sq_a.push_back(stage_a); end
    if (calc_b) begin calc_cnt[1]++; sq_b.push_back(stage_b); end
    if (done_a) done_cnt[0]++;
    if (done_b) done_cnt[1]++;
  end
  task automatic run_len(input bit b, input int exp_len, input string nm, input bit repulse);
    int n, d0, c0;
    logic [7:0] got;
    d0 = done_cnt[b];
    c0 = calc_cnt[b];
    if (b) sq_b.delete(); else sq_a.delete();
    @(posedge clk); #1;
    if (b) start_b = 1; else start_a = 1;
    @(posedge clk); #1;
    start_a = 0;
    start_b = 0;
    check({nm, "_first"}, b ? {fill_b, addr_b} : {fill_a, addr_a}, 5'h10);
    n = 1;
    while (!(b ? done_b : done_a) && n < 400) begin
      @(posedge clk); #1;
      n++;
      if (repulse) start_a = (n == 5 || n == 30 || n == 100);
    end
    check({nm, "_len"}, n, exp_len);
    if (repulse) start_a = 1;
    @(posedge clk); #1;
    start_a = 0;
    check({nm, "_busy_fall"}, b ? busy_b : busy_a, 0);
    check({nm, "_done_once"}, done_cnt[b], d0 + 1);
    check({nm, "_calc_cnt"}, calc_cnt[b] - c0, 4);
    got = '0;
    if (b) foreach (sq_b[i]) got = {got[5:0], sq_b[i]};
    else foreach (sq_a[i]) got = {got[5:0], sq_a[i]};
    check({nm, "_calc_stages"}, got, 8'b00_01_10_11);
  endtask
  initial begin
    #1 rst = 1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_a", pack_a, 0);
    check("reset_b", pack_b, 0);
    rst = 0;
    run_len(0, 101, "run_a", 0);
    run_len(0, 101, "repulse_a", 1);
    run_len(1, 73, "run_b", 0);
    @(posedge clk); #1;
    start_a = 1;
    @(posedge clk); #1;
    start_a = 0;
    for (int i = 0; i < 200 && ka != 2 * 25 + N + 3; i++) begin
      @(posedge clk); #1;
    end
    check("wait_stage2_reached", ka, 2 * 25 + N + 3);
    #2 rst = 1;
    #1;
    check("async_rst_a", pack_a, 0);
    @(posedge clk); #1;
    rst = 0;
    run_len(0, 101, "after_rst_a", 0);
`ifdef FFT_CTRL_ABORT_EN
    begin
      int d0;
      d0 = done_cnt[0];
      @(posedge clk); #1;
      start_a = 1;
      @(posedge clk); #1;
      start_a = 0;
      for (int i = 0; i < 200 && ka != 25 + 7; i++) begin
        @(posedge clk); #1;
      end
      check("abort_at_addr7", {stage_a, addr_a}, 6'h17);
      abort_a = 1;
      @(posedge clk); #1;
      abort_a = 0;
      check("abort_idle", pack_a, 0);
      @(posedge clk); #1;
      check("abort_no_done", done_cnt[0], d0);
      run_len(0, 101, "after_abort_a", 0);
    end
`endif
    repeat (2000) begin
      @(posedge clk); #1;
      start_a = $urandom_range(0, 29) == 0;
      start_b = $urandom_range(0, 29) == 0;
      rst = $urandom_range(0, 399) == 0;
`ifdef FFT_CTRL_ABORT_EN
      abort_a = $urandom_range(0, 149) == 0;
      abort_b = $urandom_range(0, 149) == 0;
`endif
    end
    @(posedge clk); #1;
    start_a = 0;
    start_b = 0;
    rst = 0;
    abort_a = 0;
    abort_b = 0;
    repeat (3) @(posedge clk);
    #2;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
